// File: rtl/cpu_clk_pkg.sv
// Shared types and constants for the CPU clock sequencer.
// No logic; no latency.
// No flow control.
package cpu_clk_pkg;

    typedef enum logic [1:0] {
        HALT = 2'd0,
        RUN  = 2'd1,
        STEP = 2'd2,
        STOP = 2'd3
    } clk_state_t;

    localparam logic [24:0] DIV_SIM   = 25'd4;
    localparam logic [24:0] DIV_BOARD = 25'h1FAF080;

endpackage

// File: rtl/clk_div_core.sv
// Enable-gated divide-by-2(div+1) counter with a registered toggle output.
// clk_out changes on the edge where rise/fall are high; rise/fall are same-cycle strobes.
// No flow control; clr overrides en and forces count and clock low.
module clk_div_core #(
    parameter int CNT_W = 25
) (
    input  logic             sys_clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             clr,
    input  logic [CNT_W-1:0] div,
    output logic             clk_out,
    output logic             rise,
    output logic             fall
);

    logic [CNT_W-1:0] count_q, count_d;
    logic             clk_q, clk_d;
    logic             hit;

    // rise/fall announce the toggle that the next edge will perform.
    always_comb begin
        hit     = en && (count_q == div);
        rise    = hit && !clk_q;
        fall    = hit && clk_q;
        count_d = count_q;
        clk_d   = clk_q;
        if (clr) begin
            count_d = '0;
            clk_d   = 1'b0;
        end else if (hit) begin
            count_d = '0;
            clk_d   = ~clk_q;
        end else if (en) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
            clk_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            clk_q   <= clk_d;
        end
    end

    assign clk_out = clk_q;

endmodule

// File: rtl/cpu_clk_ctrl.sv
// CPU clock sequencer: programmable divider with run, halt and single-step control.
// All outputs registered; first cpu_clk rise D+1 edges after entering RUN/STEP.
// Requests are one-cycle pulses, dropped if invalid in the current state; no queuing.
module cpu_clk_ctrl
    import cpu_clk_pkg::*;
#(
    parameter int             CNT_W     = 25,
    parameter int             CYC_W     = 32,
    parameter logic [CNT_W-1:0] DIV_RESET = CNT_W'(DIV_SIM),
    parameter bit             START_RUN = 1'b1
) (
    input  logic             sys_clk,
    input  logic             reset_n,
    input  logic             run_req,
    input  logic             halt_req,
    input  logic             step_req,
    input  logic             div_load,
    input  logic [CNT_W-1:0] div_value,
    output logic             cpu_clk,
    output logic             cpu_tick,
    output logic             running,
    output logic [CNT_W-1:0] div_cur,
    output logic [CYC_W-1:0] cycle_count
);

    clk_state_t       state_q, state_d;
    logic [CNT_W-1:0] div_cur_q, div_cur_d;
    logic [CYC_W-1:0] cycle_count_q, cycle_count_d;
    logic             cpu_tick_q, cpu_tick_d;
    logic             running_q, running_d;

    logic en, clr, rise, fall;

    clk_div_core #(.CNT_W(CNT_W)) u_div (
        .sys_clk (sys_clk),
        .reset_n (reset_n),
        .en      (en),
        .clr     (clr),
        .div     (div_cur_q),
        .clk_out (cpu_clk),
        .rise    (rise),
        .fall    (fall)
    );

    assign en  = (state_q != HALT);
    assign clr = (state_d == HALT);

    // A halt never cuts a high phase: while cpu_clk is high, leave only on the fall.
    always_comb begin
        state_d   = state_q;
        div_cur_d = div_cur_q;
        case (state_q)
            HALT: begin
                if (step_req)     state_d = STEP;
                else if (run_req) state_d = RUN;
                if (div_load)     div_cur_d = div_value;
            end
            RUN: begin
                if (halt_req) begin
                    if (!cpu_clk || fall) state_d = HALT;
                    else                  state_d = STOP;
                end
            end
            STEP: begin
                if (fall)          state_d = HALT;
                else if (halt_req) state_d = STOP;
                else if (run_req)  state_d = RUN;
            end
            STOP: begin
                if (fall) state_d = HALT;
            end
            default: state_d = HALT;
        endcase
    end

    always_comb begin
        cpu_tick_d    = rise && !clr;
        cycle_count_d = cycle_count_q + CYC_W'(cpu_tick_d);
        running_d     = (state_d != HALT);
    end

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= START_RUN ? RUN : HALT;
            div_cur_q     <= DIV_RESET;
            cycle_count_q <= '0;
            cpu_tick_q    <= 1'b0;
            running_q     <= START_RUN;
        end else begin
            state_q       <= state_d;
            div_cur_q     <= div_cur_d;
            cycle_count_q <= cycle_count_d;
            cpu_tick_q    <= cpu_tick_d;
            running_q     <= running_d;
        end
    end

    assign cpu_tick    = cpu_tick_q;
    assign running     = running_q;
    assign div_cur     = div_cur_q;
    assign cycle_count = cycle_count_q;

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// Directed bench for cpu_clk_ctrl: run/halt/step sequencing, divisor loads, reset, wrap.
// Second instance with a 4-bit cycle counter and D=0 exercises the wrap.
module tb_cpu_clk_ctrl;

    logic        sys_clk = 1'b0;
    logic        reset_n, rst4_n;
    logic        run_req, halt_req, step_req, div_load;
    logic [24:0] div_value;
    logic        cpu_clk, cpu_tick, running;
    logic [24:0] div_cur;
    logic [31:0] cycle_count;

    logic        clk4, tick4, run4;
    logic [24:0] divc4;
    logic [3:0]  cyc4;

    int checks = 0;
    int errors = 0;
    int n;

    always #5 sys_clk = ~sys_clk;

    cpu_clk_ctrl dut (
        .sys_clk     (sys_clk),
        .reset_n     (reset_n),
        .run_req     (run_req),
        .halt_req    (halt_req),
        .step_req    (step_req),
        .div_load    (div_load),
        .div_value   (div_value),
        .cpu_clk     (cpu_clk),
        .cpu_tick    (cpu_tick),
        .running     (running),
        .div_cur     (div_cur),
        .cycle_count (cycle_count)
    );

    cpu_clk_ctrl #(.CYC_W(4), .DIV_RESET(25'd0), .START_RUN(1'b1)) dut4 (
        .sys_clk     (sys_clk),
        .reset_n     (rst4_n),
        .run_req     (1'b0),
        .halt_req    (1'b0),
        .step_req    (1'b0),
        .div_load    (1'b0),
        .div_value   (25'd0),
        .cpu_clk     (clk4),
        .cpu_tick    (tick4),
        .running     (run4),
        .div_cur     (divc4),
        .cycle_count (cyc4)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    task automatic step1();
        @(posedge sys_clk);
        #1;
    endtask

    // Edges until the next cpu_tick; 999 on timeout so the caller's check fails.
    task automatic wait_rise(output int cnt);
        cnt = 0;
        for (int i = 0; i < 200; i++) begin
            step1();
            cnt++;
            if (cpu_tick) break;
        end
        if (!cpu_tick) cnt = 999;
    endtask

    // Called on the sample where cpu_clk just rose; returns high samples, ends on first low one.
    task automatic high_len(output int cnt);
        cnt = 1;
        for (int i = 0; i < 200; i++) begin
            step1();
            if (!cpu_clk) break;
            cnt++;
        end
    endtask

    task automatic count_ticks(input int cycles, output int cnt);
        cnt = 0;
        for (int i = 0; i < cycles; i++) begin
            step1();
            if (cpu_tick) cnt++;
        end
    endtask

    initial begin
        reset_n   = 1'b0;
        rst4_n    = 1'b0;
        run_req   = 1'b0;
        halt_req  = 1'b0;
        step_req  = 1'b0;
        div_load  = 1'b0;
        div_value = 25'd0;
        #12;
        chk("rst_cpu_clk", 32'(cpu_clk), 0);
        chk("rst_tick", 32'(cpu_tick), 0);
        chk("rst_cycles", cycle_count, 0);
        chk("rst_div", 32'(div_cur), 4);
        chk("rst_running", 32'(running), 1);

        step1();
        reset_n = 1'b1;
        rst4_n  = 1'b1;

        // Free-run from reset, D=4.
        wait_rise(n);
        chk("first_rise_edge", n, 5);
        chk("cycles_1", cycle_count, 1);
        wait_rise(n);
        chk("period_a", n, 10);
        wait_rise(n);
        chk("period_b", n, 10);
        chk("cycles_3", cycle_count, 3);

        // Halt one cycle after a rise, with an illegal divisor load alongside.
        halt_req  = 1'b1;
        div_load  = 1'b1;
        div_value = 25'd1;
        step1();
        halt_req  = 1'b0;
        div_load  = 1'b0;
        chk("div_load_run_ignored", 32'(div_cur), 4);
        chk("stop_running", 32'(running), 1);
        n = 2;
        for (int i = 0; i < 50; i++) begin
            step1();
            if (!cpu_clk) break;
            n++;
        end
        chk("stop_high_len", n, 5);
        chk("stop_to_halt", 32'(running), 0);
        count_ticks(30, n);
        chk("halt_no_ticks", n, 0);
        chk("cycles_after_halt", cycle_count, 3);

        // Load D=1 in HALT and run.
        div_load  = 1'b1;
        div_value = 25'd1;
        step1();
        div_load  = 1'b0;
        chk("div_load_halt", 32'(div_cur), 1);
        run_req = 1'b1;
        step1();
        run_req = 1'b0;
        chk("run_running", 32'(running), 1);
        wait_rise(n);
        chk("d1_first_rise", n, 2);
        chk("cycles_4", cycle_count, 4);
        high_len(n);
        chk("d1_high", n, 2);
        wait_rise(n);
        chk("d1_low", n, 2);
        chk("cycles_5", cycle_count, 5);

        // All three requests in RUN while cpu_clk is low: immediate HALT.
        for (int i = 0; i < 10; i++) begin
            if (!cpu_clk) break;
            step1();
        end
        halt_req = 1'b1;
        step_req = 1'b1;
        run_req  = 1'b1;
        step1();
        halt_req = 1'b0;
        step_req = 1'b0;
        run_req  = 1'b0;
        chk("all_req_run_halt", 32'(running), 0);
        chk("all_req_run_clk", 32'(cpu_clk), 0);
        count_ticks(20, n);
        chk("all_req_run_noticks", n, 0);

        // Single step with D=2.
        div_load  = 1'b1;
        div_value = 25'd2;
        step1();
        div_load  = 1'b0;
        chk("div_load_2", 32'(div_cur), 2);
        step_req = 1'b1;
        step1();
        step_req = 1'b0;
        chk("step_running", 32'(running), 1);
        wait_rise(n);
        chk("step_rise", n, 3);
        chk("cycles_6", cycle_count, 6);
        high_len(n);
        chk("step_high", n, 3);
        chk("step_done_halt", 32'(running), 0);
        count_ticks(20, n);
        chk("step_single_tick", n, 0);
        chk("cycles_6_hold", cycle_count, 6);

        // All three requests in HALT: step wins.
        halt_req = 1'b1;
        step_req = 1'b1;
        run_req  = 1'b1;
        step1();
        halt_req = 1'b0;
        step_req = 1'b0;
        run_req  = 1'b0;
        chk("all_req_halt_step", 32'(running), 1);
        wait_rise(n);
        chk("all_req_step_rise", n, 3);
        high_len(n);
        chk("all_req_step_high", n, 3);
        chk("all_req_step_halt", 32'(running), 0);
        count_ticks(20, n);
        chk("all_req_step_single", n, 0);
        chk("cycles_7", cycle_count, 7);

        // Asynchronous reset in the middle of a high phase.
        run_req = 1'b1;
        step1();
        run_req = 1'b0;
        wait_rise(n);
        chk("pre_reset_rise", n, 3);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_cpu_clk", 32'(cpu_clk), 0);
        chk("arst_tick", 32'(cpu_tick), 0);
        chk("arst_cycles", cycle_count, 0);
        chk("arst_div", 32'(div_cur), 4);
        chk("arst_running", 32'(running), 1);
        step1();
        reset_n = 1'b1;

        // 4-bit cycle counter wraps 15 -> 0.
        rst4_n = 1'b0;
        #1;
        chk("wrap_rst", 32'(cyc4), 0);
        step1();
        rst4_n = 1'b1;
        n = 0;
        for (int i = 0; i < 100 && n < 15; i++) begin
            step1();
            if (tick4) n++;
        end
        chk("wrap_15", 32'(cyc4), 15);
        n = 0;
        for (int i = 0; i < 10 && n < 1; i++) begin
            step1();
            if (tick4) n++;
        end
        chk("wrap_0", 32'(cyc4), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
